// File: rtl/mips_defs.sv
// mips_defs: shared definitions for the MIPS core front end.
//   RESET_PC / IM_BASE / IM_LAST : reset PC and legal instruction-memory window
//   EXC_VECTOR                   : exception entry address (used by the flush source)
//   fetch_state_t                : fetch sequencer state encoding
//   fetch_word_t                 : one fetched entry {instr, pc, adel}
//   fetch_addr_illegal()         : misaligned or out-of-window fetch address test
package mips_defs;

  localparam logic [31:0] RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] IM_BASE    = 32'h0000_3000;
  localparam logic [31:0] IM_LAST    = 32'h0000_6FFC;
  localparam logic [31:0] EXC_VECTOR = 32'h0000_4180;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,  // request outstanding or about to issue
    ST_HOLD  = 2'd1,  // one instruction parked in the skid entry, no request
    ST_DRAIN = 2'd2   // discarding an in-flight fetch after a flush
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        adel;
  } fetch_word_t;

  // A fetch address is illegal when it is not word aligned or lies outside
  // the instruction-memory window [lo, hi].
  function automatic logic fetch_addr_illegal(input logic [31:0] addr,
                                              input logic [31:0] lo,
                                              input logic [31:0] hi);
    return (addr[1:0] != 2'b00) || (addr < lo) || (addr > hi);
  endfunction

endpackage

// File: rtl/fetch_skid.sv
// fetch_skid: one-entry holding register for a fetched instruction that
// completed while IF/ID was stalled.
//   clk, reset         : clock, asynchronous active-high reset
//   load               : capture load_instr/load_pc/load_adel, set valid
//   unload             : entry has been moved out, clear valid
//   clear              : discard the entry (flush), clear valid
//   valid/instr/pc/adel: current entry
module fetch_skid (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        unload,
  input  logic        clear,
  input  logic [31:0] load_instr,
  input  logic [31:0] load_pc,
  input  logic        load_adel,
  output logic        valid,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic        adel
);

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values of its inputs regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
      // NOTE: the payload is a single entry, not a RAM, so resetting it costs
      // nothing and keeps the held values defined after reset.
      instr <= '0;
      pc    <= '0;
      adel  <= 1'b0;
    end else if (clear || unload) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      instr <= load_instr;
      pc    <= load_pc;
      adel  <= load_adel;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer. Owns the PC, drives a
// variable-latency instruction-memory handshake and loads IF/ID.
//   clk, reset                : clock, asynchronous active-high reset
//   im_req/im_addr            : fetch request, address held until im_ack
//   im_ack/im_rdata           : memory response and instruction word
//   stall                     : ID cannot accept, IF/ID holds
//   redirect_valid/redirect_pc: taken branch/jump from ID (delayed branch)
//   flush_valid/flush_pc      : exception entry or eret, highest priority
//   if_id_*                   : IF/ID pipeline register contents
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = mips_defs::RESET_PC,
  parameter logic [31:0] IM_BASE  = mips_defs::IM_BASE,
  parameter logic [31:0] IM_LAST  = mips_defs::IM_LAST
) (
  input  logic        clk,
  input  logic        reset,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic        im_ack,
  input  logic [31:0] im_rdata,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        flush_valid,
  input  logic [31:0] flush_pc,
  output logic        if_id_valid,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc,
  output logic        if_id_adel
);

  import mips_defs::*;

  fetch_state_t state, state_next;

  logic [31:0] pc, pc_next;
  logic        pend_valid, pend_valid_next;
  logic [31:0] pend_pc, pend_pc_next;
  logic [31:0] drain_addr, drain_addr_next;

  logic        pc_illegal;
  logic        fetch_done;
  fetch_word_t fetched;
  fetch_word_t ifid_word;
  logic        ifid_load;
  logic        ifid_drop;

  logic        skid_load, skid_unload, skid_clear;
  logic        skid_valid;
  logic [31:0] skid_instr, skid_pc;
  logic        skid_adel;

  fetch_skid u_skid (
    .clk        (clk),
    .reset      (reset),
    .load       (skid_load),
    .unload     (skid_unload),
    .clear      (skid_clear),
    .load_instr (fetched.instr),
    .load_pc    (fetched.pc),
    .load_adel  (fetched.adel),
    .valid      (skid_valid),
    .instr      (skid_instr),
    .pc         (skid_pc),
    .adel       (skid_adel)
  );

  // An illegal PC never reaches memory: it completes internally in one
  // cycle as an address-error entry with a zero instruction.
  assign pc_illegal = fetch_addr_illegal(pc, IM_BASE, IM_LAST);
  assign fetch_done = (state == ST_FETCH) && (pc_illegal || im_ack);

  assign fetched.instr = pc_illegal ? 32'h0 : im_rdata;
  assign fetched.pc    = pc;
  assign fetched.adel  = pc_illegal;

  // During DRAIN the abandoned request keeps its original address until the
  // memory acks it; PC already holds the flush target.
  assign im_req  = ((state == ST_FETCH) && !pc_illegal) || (state == ST_DRAIN);
  assign im_addr = (state == ST_DRAIN) ? drain_addr : pc;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_next      = state;
    pc_next         = pc;
    pend_valid_next = pend_valid;
    pend_pc_next    = pend_pc;
    drain_addr_next = drain_addr;
    ifid_load       = 1'b0;
    ifid_drop       = 1'b0;
    ifid_word       = fetched;
    skid_load       = 1'b0;
    skid_unload     = 1'b0;
    skid_clear      = 1'b0;

    unique case (state)
      ST_FETCH: begin
        if (fetch_done) begin
          if (!if_id_valid || !stall) begin
            ifid_load = 1'b1;
          end else begin
            skid_load  = 1'b1;
            state_next = ST_HOLD;
          end
          // The completing fetch is the delay slot when a redirect is pending
          // or arrives now, so the target becomes the next PC.
          if (redirect_valid)  pc_next = redirect_pc;
          else if (pend_valid) pc_next = pend_pc;
          else                 pc_next = pc + 32'd4;
          pend_valid_next = 1'b0;
        end else begin
          if (!stall) ifid_drop = 1'b1;
          if (redirect_valid) begin
            pend_valid_next = 1'b1;
            pend_pc_next    = redirect_pc;
          end
        end
      end
      ST_HOLD: begin
        if (!stall && skid_valid) begin
          ifid_load   = 1'b1;
          ifid_word   = '{instr: skid_instr, pc: skid_pc, adel: skid_adel};
          skid_unload = 1'b1;
          state_next  = ST_FETCH;
        end
        // The delay slot is already parked, so the target goes straight to PC.
        if (redirect_valid) pc_next = redirect_pc;
      end
      ST_DRAIN: begin
        if (!stall) ifid_drop = 1'b1;
        if (im_ack) state_next = ST_FETCH;
      end
      default: state_next = ST_FETCH;
    endcase

    // Flush overrides every same-cycle event.
    if (flush_valid) begin
      ifid_load       = 1'b0;
      ifid_drop       = 1'b1;
      skid_load       = 1'b0;
      skid_unload     = 1'b0;
      skid_clear      = 1'b1;
      pend_valid_next = 1'b0;
      pc_next         = flush_pc;
      if ((state == ST_FETCH) && im_req && !im_ack) begin
        state_next      = ST_DRAIN;
        drain_addr_next = pc;
      end else if ((state == ST_DRAIN) && !im_ack) begin
        state_next = ST_DRAIN;
      end else begin
        state_next = ST_FETCH;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_FETCH;
      pc         <= RESET_PC;
      pend_valid <= 1'b0;
      pend_pc    <= '0;
      drain_addr <= '0;
    end else begin
      state      <= state_next;
      pc         <= pc_next;
      pend_valid <= pend_valid_next;
      pend_pc    <= pend_pc_next;
      drain_addr <= drain_addr_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      if_id_valid <= 1'b0;
      if_id_instr <= '0;
      if_id_pc    <= '0;
      if_id_adel  <= 1'b0;
    end else if (ifid_load) begin
      if_id_valid <= 1'b1;
      if_id_instr <= ifid_word.instr;
      if_id_pc    <= ifid_word.pc;
      if_id_adel  <= ifid_word.adel;
    end else if (ifid_drop) begin
      if_id_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;

  logic        clk;
  logic        reset;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_ack = 1'b0;
  logic [31:0] im_rdata = 32'h0;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush_valid;
  logic [31:0] flush_pc;
  logic        if_id_valid;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc;
  logic        if_id_adel;

  int checks = 0;
  int errors = 0;
  int wait_n = 0;
  int cnt    = 0;

  fetch_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .im_req         (im_req),
    .im_addr        (im_addr),
    .im_ack         (im_ack),
    .im_rdata       (im_rdata),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .flush_valid    (flush_valid),
    .flush_pc       (flush_pc),
    .if_id_valid    (if_id_valid),
    .if_id_instr    (if_id_instr),
    .if_id_pc       (if_id_pc),
    .if_id_adel     (if_id_adel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: acks a request after wait_n idle cycles; data = ~address.
  always @(negedge clk) begin
    if (reset || !im_req) begin
      im_ack = 1'b0;
      cnt    = 0;
    end else begin
      if (im_ack) cnt = 0;
      if (cnt == wait_n) begin
        im_ack   = 1'b1;
        im_rdata = ~im_addr;
      end else begin
        im_ack = 1'b0;
        cnt++;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int w);
    reset          = 1'b1;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    flush_valid    = 1'b0;
    flush_pc       = 32'h0;
    wait_n         = w;
    tick;
    tick;
    reset = 1'b0;
  endtask

  task automatic run_until_ifid(input string tag, input logic [31:0] pc, input int budget);
    logic found;
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      tick;
      if (if_id_valid && if_id_pc == pc) found = 1'b1;
    end
    check(tag, {31'b0, found}, 32'd1);
  endtask

  initial begin
    // Reset values
    reset          = 1'b1;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    flush_valid    = 1'b0;
    flush_pc       = 32'h0;
    wait_n         = 0;
    tick;
    check("rst_im_req",  {31'b0, im_req},      32'd1);
    check("rst_im_addr", im_addr,              32'h0000_3000);
    check("rst_valid",   {31'b0, if_id_valid}, 32'd0);
    check("rst_instr",   if_id_instr,          32'h0);
    check("rst_pc",      if_id_pc,             32'h0);
    check("rst_adel",    {31'b0, if_id_adel},  32'd0);

    // Zero-wait memory: one instruction per edge
    reset = 1'b0;
    tick;
    check("zw_pc0",    if_id_pc,             32'h0000_3000);
    check("zw_instr0", if_id_instr,          32'hFFFF_CFFF);
    check("zw_valid0", {31'b0, if_id_valid}, 32'd1);
    tick;
    check("zw_pc1", if_id_pc, 32'h0000_3004);
    tick;
    check("zw_pc2", if_id_pc, 32'h0000_3008);

    // Two-wait memory with stall: 0x3004 parks in the skid
    do_reset(2);
    repeat (3) tick;
    check("st_pc0", if_id_pc, 32'h0000_3000);
    stall = 1'b1;
    repeat (3) tick;
    check("st_hold_req",   {31'b0, im_req},      32'd0);
    check("st_hold_pc",    if_id_pc,             32'h0000_3000);
    check("st_hold_valid", {31'b0, if_id_valid}, 32'd1);
    stall = 1'b0;
    tick;
    check("st_skid_pc",    if_id_pc,        32'h0000_3004);
    check("st_skid_instr", if_id_instr,     32'hFFFF_CFFB);
    check("st_next_req",   {31'b0, im_req}, 32'd1);
    check("st_next_addr",  im_addr,         32'h0000_3008);

    // Redirect while the delay slot 0x3014 is outstanding
    do_reset(2);
    run_until_ifid("br_wait", 32'h0000_3010, 40);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_3100;
    tick;
    redirect_valid = 1'b0;
    check("br_pend_addr", im_addr, 32'h0000_3014);
    repeat (2) tick;
    check("br_ds_pc",   if_id_pc, 32'h0000_3014);
    check("br_tgt_req", im_addr,  32'h0000_3100);
    repeat (3) tick;
    check("br_tgt_pc",    if_id_pc,    32'h0000_3100);
    check("br_tgt_instr", if_id_instr, 32'hFFFF_CEFF);

    // Redirect in the same cycle as the 0x3014 ack
    do_reset(2);
    run_until_ifid("bs_wait", 32'h0000_3010, 40);
    repeat (2) tick;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_3100;
    tick;
    redirect_valid = 1'b0;
    check("bs_ds_pc",   if_id_pc, 32'h0000_3014);
    check("bs_tgt_req", im_addr,  32'h0000_3100);
    repeat (3) tick;
    check("bs_tgt_pc", if_id_pc, 32'h0000_3100);

    // Flush while 0x3020 waits three cycles
    do_reset(3);
    run_until_ifid("fl_wait", 32'h0000_301C, 60);
    flush_valid = 1'b1;
    flush_pc    = 32'h0000_4180;
    tick;
    flush_valid = 1'b0;
    check("fl_drain_valid", {31'b0, if_id_valid}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      tick;
      check("fl_drain_addr", im_addr,         32'h0000_3020);
      check("fl_drain_req",  {31'b0, im_req}, 32'd1);
    end
    tick;
    check("fl_new_addr",  im_addr,              32'h0000_4180);
    check("fl_new_valid", {31'b0, if_id_valid}, 32'd0);
    repeat (3) tick;
    check("fl_no_old", {31'b0, if_id_valid}, 32'd0);
    tick;
    check("fl_vec_pc",    if_id_pc,             32'h0000_4180);
    check("fl_vec_valid", {31'b0, if_id_valid}, 32'd1);

    // Misaligned redirect target
    do_reset(0);
    run_until_ifid("ma_wait", 32'h0000_3008, 10);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_3102;
    tick;
    redirect_valid = 1'b0;
    check("ma_ds_pc",  if_id_pc,        32'h0000_300C);
    check("ma_no_req", {31'b0, im_req}, 32'd0);
    tick;
    check("ma_valid", {31'b0, if_id_valid}, 32'd1);
    check("ma_pc",    if_id_pc,             32'h0000_3102);
    check("ma_adel",  {31'b0, if_id_adel},  32'd1);
    check("ma_instr", if_id_instr,          32'h0);

    // First address above the instruction window
    do_reset(0);
    run_until_ifid("oob_wait", 32'h0000_3008, 10);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_7000;
    tick;
    redirect_valid = 1'b0;
    check("oob_no_req", {31'b0, im_req}, 32'd0);
    tick;
    check("oob_valid", {31'b0, if_id_valid}, 32'd1);
    check("oob_pc",    if_id_pc,             32'h0000_7000);
    check("oob_adel",  {31'b0, if_id_adel},  32'd1);
    check("oob_instr", if_id_instr,          32'h0);

    // Flush and redirect in the same cycle: flush wins, redirect dropped
    do_reset(2);
    run_until_ifid("fr_wait", 32'h0000_3010, 40);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_3100;
    flush_valid    = 1'b1;
    flush_pc       = 32'h0000_4180;
    tick;
    redirect_valid = 1'b0;
    flush_valid    = 1'b0;
    check("fr_drain_addr", im_addr,              32'h0000_3014);
    check("fr_valid",      {31'b0, if_id_valid}, 32'd0);
    repeat (2) tick;
    check("fr_new_addr", im_addr, 32'h0000_4180);
    repeat (3) tick;
    check("fr_vec_pc",    if_id_pc, 32'h0000_4180);
    check("fr_next_addr", im_addr,  32'h0000_4184);

    // Reset asserted mid-DRAIN
    do_reset(3);
    run_until_ifid("rd_wait", 32'h0000_3000, 10);
    flush_valid = 1'b1;
    flush_pc    = 32'h0000_4180;
    tick;
    flush_valid = 1'b0;
    check("rd_drain_addr", im_addr, 32'h0000_3004);
    #2;
    reset = 1'b1;
    #1;
    check("rd_im_req",  {31'b0, im_req},      32'd1);
    check("rd_im_addr", im_addr,              32'h0000_3000);
    check("rd_valid",   {31'b0, if_id_valid}, 32'd0);
    check("rd_pc",      if_id_pc,             32'h0);
    check("rd_instr",   if_id_instr,          32'h0);
    check("rd_adel",    {31'b0, if_id_adel},  32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
